// File: rtl/instr_l1_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_l1_refill_ctrl
// Brief    : Instruction L1 line refill controller; fetches one line word by
//            word from next-level memory and writes it into the L1 array.
//            Optional REFILL_CRIT_WORD_FIRST_EN starts at the missing word.
// Revision : 1.0 - initial release
// ============================================================================
module instr_l1_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              l1_wr_en,
    output logic [ADDR_W-1:0] l1_wr_addr,
    output logic [ADDR_W-1:0] l1_wr_data,
    output logic              fetch_stall,
    output logic              refill_done
);

    localparam int c_IDX_W = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_readyEn;
    logic [ADDR_W-1:0]   r_lineBase;
    logic [c_IDX_W-1:0]  r_index;
    logic [c_IDX_W-1:0]  r_beatCnt;
    logic [ADDR_W-1:0]   r_wordData;

    logic [ADDR_W-1:0]   w_lineMask;
    logic [ADDR_W-1:0]   w_curAddr;
    logic [c_IDX_W-1:0]  w_startOff;
    logic                w_accept;
    logic                w_lastBeat;

    assign w_lineMask = {{(ADDR_W-c_IDX_W){1'b1}}, {c_IDX_W{1'b0}}};
    // Index is confined to the low bits, so the word address never leaves the line.
    assign w_curAddr  = r_lineBase | {{(ADDR_W-c_IDX_W){1'b0}}, r_index};
    assign w_lastBeat = (r_beatCnt == c_IDX_W'(LINE_WORDS-1));
    assign w_accept   = (r_state == IDLE) && miss_valid && miss_ready;

`ifdef REFILL_CRIT_WORD_FIRST_EN
    assign w_startOff = miss_addr[c_IDX_W-1:0];
`else
    assign w_startOff = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        miss_ready  = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        l1_wr_en    = 1'b0;
        l1_wr_addr  = '0;
        l1_wr_data  = '0;
        fetch_stall = 1'b1;
        refill_done = 1'b0;
        case (r_state)
            IDLE: begin
                // Ready is held low until the first clean edge after reset.
                miss_ready  = r_readyEn;
                fetch_stall = 1'b0;
                if (miss_valid && r_readyEn) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = w_curAddr;
                if (mem_ack) begin
                    w_nextState = WRITE;
                end
            end
            WRITE: begin
                l1_wr_en    = 1'b1;
                l1_wr_addr  = w_curAddr;
                l1_wr_data  = r_wordData;
                w_nextState = w_lastBeat ? DONE : REQ;
            end
            DONE: begin
                refill_done = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_readyEn  <= 1'b0;
            r_lineBase <= '0;
            r_index    <= '0;
            r_beatCnt  <= '0;
            r_wordData <= '0;
        end else begin
            r_readyEn <= 1'b1;
            if (w_accept) begin
                r_lineBase <= miss_addr & w_lineMask;
                r_index    <= w_startOff;
                r_beatCnt  <= '0;
            end
            if ((r_state == REQ) && mem_ack) begin
                r_wordData <= mem_rdata;
            end
            if ((r_state == WRITE) && !w_lastBeat) begin
                r_beatCnt <= r_beatCnt + c_IDX_W'(1);
                r_index   <= r_index + c_IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_l1_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_l1_refill_ctrl
// Brief    : Directed self-checking bench for instr_l1_refill_ctrl (LINE_WORDS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_l1_refill_ctrl;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        miss_valid = 1'b0;
    logic [15:0] miss_addr  = 16'h0000;
    logic        mem_ack    = 1'b0;
    logic [15:0] mem_rdata  = 16'h0000;
    logic        miss_ready;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        l1_wr_en;
    logic [15:0] l1_wr_addr;
    logic [15:0] l1_wr_data;
    logic        fetch_stall;
    logic        refill_done;

    int nTests = 0;
    int nFail  = 0;

`ifdef REFILL_CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    instr_l1_refill_ctrl #(.LINE_WORDS(4), .ADDR_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .miss_valid  (miss_valid),
        .miss_addr   (miss_addr),
        .miss_ready  (miss_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .l1_wr_en    (l1_wr_en),
        .l1_wr_addr  (l1_wr_addr),
        .l1_wr_data  (l1_wr_data),
        .fetch_stall (fetch_stall),
        .refill_done (refill_done)
    );

    always #5 clk = ~clk;

    // One full refill; order holds the four expected word addresses, beat 0 in the low bits.
    task automatic refill(input logic [15:0] addr, input logic [63:0] order, input int dly,
                          input int abortAfter, input bit spurious, input bit holdSecond);
        logic [15:0] exp;
        logic [15:0] dat;
        @(negedge clk);
        nTests++;
        if ({miss_ready, fetch_stall} !== 2'b10) begin
            nFail++;
            $display("FAIL pre_accept addr=%h: ready/stall got %b%b, expected 10", addr, miss_ready, fetch_stall);
        end
        miss_valid = 1'b1;
        miss_addr  = addr;
        @(negedge clk);
        miss_valid = holdSecond;
        miss_addr  = holdSecond ? 16'h0010 : 16'h0000;
        for (int k = 0; k < 4; k++) begin
            exp = order[16*k +: 16];
            dat = exp ^ 16'h3C5A;
            for (int w = 0; w <= dly; w++) begin
                nTests++;
                if ({mem_req, mem_addr, l1_wr_en, fetch_stall, miss_ready, refill_done}
                    !== {1'b1, exp, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                    nFail++;
                    $display("FAIL req beat%0d wait%0d: req=%b addr=%h wr=%b stall=%b rdy=%b done=%b, expected req=1 addr=%h wr=0 stall=1 rdy=0 done=0",
                             k, w, mem_req, mem_addr, l1_wr_en, fetch_stall, miss_ready, refill_done, exp);
                end
                mem_ack   = (w == dly);
                mem_rdata = (w == dly) ? dat : 16'hDEAD;
                @(negedge clk);
            end
            mem_ack   = spurious;
            mem_rdata = 16'hBEEF;
            nTests++;
            if ({l1_wr_en, l1_wr_addr, l1_wr_data, mem_req, mem_addr, refill_done, miss_ready}
                !== {1'b1, exp, dat, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
                nFail++;
                $display("FAIL write beat%0d: wr=%b waddr=%h wdata=%h req=%b maddr=%h done=%b rdy=%b, expected wr=1 waddr=%h wdata=%h req=0 maddr=0000 done=0 rdy=0",
                         k, l1_wr_en, l1_wr_addr, l1_wr_data, mem_req, mem_addr, refill_done, miss_ready, exp, dat);
            end
            if (abortAfter == k + 1) begin
                rst_n = 1'b0;
                @(negedge clk);
                mem_ack    = 1'b0;
                miss_valid = 1'b0;
                nTests++;
                if ({miss_ready, mem_req, mem_addr, l1_wr_en, l1_wr_addr, l1_wr_data, fetch_stall, refill_done} !== 52'h0) begin
                    nFail++;
                    $display("FAIL abort_outputs: rdy=%b req=%b maddr=%h wr=%b waddr=%h wdata=%h stall=%b done=%b, expected all 0",
                             miss_ready, mem_req, mem_addr, l1_wr_en, l1_wr_addr, l1_wr_data, fetch_stall, refill_done);
                end
                rst_n = 1'b1;
                @(negedge clk);
                nTests++;
                if ({miss_ready, fetch_stall, refill_done, mem_req, l1_wr_en} !== 5'b10000) begin
                    nFail++;
                    $display("FAIL abort_recover: rdy/stall/done/req/wr got %b%b%b%b%b, expected 10000",
                             miss_ready, fetch_stall, refill_done, mem_req, l1_wr_en);
                end
                return;
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        nTests++;
        if ({refill_done, fetch_stall, miss_ready, l1_wr_en, mem_req, mem_addr, l1_wr_data} !== {5'b11000, 32'h0}) begin
            nFail++;
            $display("FAIL done addr=%h: done=%b stall=%b rdy=%b wr=%b req=%b maddr=%h wdata=%h, expected done=1 stall=1 rest 0",
                     addr, refill_done, fetch_stall, miss_ready, l1_wr_en, mem_req, mem_addr, l1_wr_data);
        end
        miss_valid = 1'b0;
        miss_addr  = 16'h0000;
        @(negedge clk);
        nTests++;
        if ({refill_done, fetch_stall, miss_ready, l1_wr_en, mem_req} !== 5'b00100) begin
            nFail++;
            $display("FAIL post_done addr=%h: done/stall/rdy/wr/req got %b%b%b%b%b, expected 00100",
                     addr, refill_done, fetch_stall, miss_ready, l1_wr_en, mem_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        nTests++;
        if ({miss_ready, mem_req, mem_addr, l1_wr_en, l1_wr_addr, l1_wr_data, fetch_stall, refill_done} !== 52'h0) begin
            nFail++;
            $display("FAIL reset_outputs: rdy=%b req=%b maddr=%h wr=%b waddr=%h wdata=%h stall=%b done=%b, expected all 0",
                     miss_ready, mem_req, mem_addr, l1_wr_en, l1_wr_addr, l1_wr_data, fetch_stall, refill_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        nTests++;
        if ({miss_ready, fetch_stall, mem_req, l1_wr_en, refill_done} !== 5'b10000) begin
            nFail++;
            $display("FAIL reset_release: rdy/stall/req/wr/done got %b%b%b%b%b, expected 10000",
                     miss_ready, fetch_stall, mem_req, l1_wr_en, refill_done);
        end
    endtask

    task automatic test_sequential();
        refill(16'h0008, {16'h000B, 16'h000A, 16'h0009, 16'h0008}, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_crit_word();
        if (CWF) refill(16'h0006, {16'h0005, 16'h0004, 16'h0007, 16'h0006}, 0, 0, 1'b0, 1'b0);
        else     refill(16'h0006, {16'h0007, 16'h0006, 16'h0005, 16'h0004}, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ack_delay();
        refill(16'h0020, {16'h0023, 16'h0022, 16'h0021, 16'h0020}, 3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_busy_miss();
        refill(16'h0000, {16'h0003, 16'h0002, 16'h0001, 16'h0000}, 0, 0, 1'b0, 1'b1);
        refill(16'h0010, {16'h0013, 16'h0012, 16'h0011, 16'h0010}, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_top();
        if (CWF) refill(16'hFFFE, {16'hFFFD, 16'hFFFC, 16'hFFFF, 16'hFFFE}, 0, 0, 1'b0, 1'b0);
        else     refill(16'hFFFE, {16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC}, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_spurious_ack();
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nTests++;
            if ({miss_ready, fetch_stall, mem_req, l1_wr_en, l1_wr_data} !== {4'b1000, 16'h0000}) begin
                nFail++;
                $display("FAIL idle_ack cyc%0d: rdy=%b stall=%b req=%b wr=%b wdata=%h, expected rdy=1 others 0",
                         i, miss_ready, fetch_stall, mem_req, l1_wr_en, l1_wr_data);
            end
        end
        mem_ack = 1'b0;
        refill(16'h0104, {16'h0107, 16'h0106, 16'h0105, 16'h0104}, 1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        refill(16'h0030, {16'h0033, 16'h0032, 16'h0031, 16'h0030}, 0, 2, 1'b0, 1'b0);
        refill(16'h0030, {16'h0033, 16'h0032, 16'h0031, 16'h0030}, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_crit_word();
        test_ack_delay();
        test_busy_miss();
        test_wrap_top();
        test_spurious_ack();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
